mips_mc_controller: RTL

Control unit for the multicycle MIPS core. A Moore state machine sequences the shared datapath (single memory, register file, one ALU, PC/IR/data registers) through fetch, decode, execute, memory and write-back cycles. A combinational ALU decoder and the PC-enable logic complete the controller. It sits beside the datapath inside the top-level `main` and drives every datapath enable and mux select.

---
 rtl/mips_pkg.sv | 42 ++++
 rtl/mips_aludec.sv | 28 ++
 rtl/mips_mc_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multicycle MIPS controller
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_ADDIEX,
        S_ADDIWB,
        S_JEX
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

endpackage

// File: rtl/mips_aludec.sv
// rtl/mips_aludec.sv - combinational ALU decoder from aluop and funct
module mips_aludec
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALUCTL_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALUCTL_ADD;
                    FUNCT_SUB: alucontrol = ALUCTL_SUB;
                    FUNCT_AND: alucontrol = ALUCTL_AND;
                    FUNCT_OR:  alucontrol = ALUCTL_OR;
                    FUNCT_SLT: alucontrol = ALUCTL_SLT;
                    default:   alucontrol = ALUCTL_ADD;
                endcase
            end
            default: alucontrol = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - Moore FSM sequencing the multicycle MIPS datapath
module mips_mc_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol
);

    state_t     state, next_state;
    logic       pcwrite, branch;
    logic       memwrite_s, irwrite_s, regwrite_s;
    logic [1:0] aluop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alusrcb    = 2'b01;
                irwrite_s  = 1'b1;
                pcwrite    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JEX;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                next_state = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: regwrite_s = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Reset parks the FSM in FETCH, so only the strobes need explicit gating.
    assign pcen     = reset & (pcwrite | (branch & zero));
    assign memwrite = reset & memwrite_s;
    assign irwrite  = reset & irwrite_s;
    assign regwrite = reset & regwrite_s;

    mips_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule
